// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared types for the hazard controller: forwarding selects, writeback info
// and the per-source hazard breakdown.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
  } wb_info_t;

  typedef struct packed {
    logic load_use;
    logic raw_busy;
    logic waw_busy;
    logic in_flight;
  } hazard_src_t;

  // Youngest producer wins: MEM result is newer than WB.
  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] src,
                                        input wb_info_t mem,
                                        input wb_info_t wb);
    fwd_sel_e sel;
    if (src == {REG_AW{1'b0}}) begin
      sel = FWD_NONE;
    end else if (mem.we && (mem.rd == src)) begin
      sel = FWD_MEM;
    end else if (wb.we && (wb.rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// Pipeline-to-hazard-controller bundle; the pipeline is master, the
// controller is slave.
interface hazard_ctrl_sb_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 32
);
  import hazard_pkg::*;

  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_we;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rs1;
  logic [ADDR_W-1:0] ex_rs2;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_we;
  logic              ex_load;
  logic              ex_long;
  logic              ex_redirect;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_rd;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic              lc_valid;
  logic [ADDR_W-1:0] lc_rd;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  fwd_sel_e          fwd_a;
  fwd_sel_e          fwd_b;
  logic [NUM_REGS-1:0] sb_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
    output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_we, ex_load, ex_long, ex_redirect,
    output mem_we, mem_rd, wb_we, wb_rd, lc_valid, lc_rd,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, sb_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
    input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_we, ex_load, ex_long, ex_redirect,
    input  mem_we, mem_rd, wb_we, wb_rd, lc_valid, lc_rd,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, sb_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sb_scoreboard.sv
// Busy-bit scoreboard for long-latency writebacks. A set and a clear of the
// same register in one cycle leave it busy; x0 is never busy.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_rd,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_rd,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;

  // Next busy vector: clear first so a same-register set overrides it
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_en) begin
      busy_nxt_s[clr_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (set_en) begin
      busy_nxt_s[set_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: stall/flush, EX forwarding selects, scoreboard and a
// stall-cycle counter. HAZARD_FWD_EN enables operand forwarding.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 32
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_sb_if.slave hz
);

  wb_info_t            ex_info_s;
  wb_info_t            mem_info_s;
  wb_info_t            wb_info_s;
  hazard_src_t         src_s;
  logic [NUM_REGS-1:0] hit_vec_s;
  logic [NUM_REGS-1:0] sb_busy_s;
  logic                hazard_s;
  logic                stall_s;
  logic                flush_id_s;
  logic                flush_ex_s;
  logic                sb_set_s;
  logic                sb_clr_s;
  fwd_sel_e            fwd_a_s;
  fwd_sel_e            fwd_b_s;
  logic [CNT_W-1:0]    stall_cnt_r;

  assign ex_info_s  = '{we: hz.ex_we,  rd: hz.ex_rd};
  assign mem_info_s = '{we: hz.mem_we, rd: hz.mem_rd};
  assign wb_info_s  = '{we: hz.wb_we,  rd: hz.wb_rd};

  // hit_vec_s[r]: the ID instruction really reads register r (never x0)
  always_comb begin
    hit_vec_s = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      hit_vec_s[r] = hz.id_valid &
                     ((hz.id_use_rs1 & (hz.id_rs1 == ADDR_W'(r))) |
                      (hz.id_use_rs2 & (hz.id_rs2 == ADDR_W'(r))));
    end
  end

  // Individual hazard sources; without forwarding every in-flight writer blocks
  always_comb begin
    src_s.load_use = hz.ex_valid & ex_info_s.we & (hz.ex_load | hz.ex_long) &
                     hit_vec_s[ex_info_s.rd];
    src_s.raw_busy = |(hit_vec_s & sb_busy_s);
    src_s.waw_busy = hz.id_valid & hz.id_we & (hz.id_rd != {ADDR_W{1'b0}}) &
                     sb_busy_s[hz.id_rd];
`ifdef HAZARD_FWD_EN
    src_s.in_flight = 1'b0;
`else
    src_s.in_flight = (hz.ex_valid & ex_info_s.we & hit_vec_s[ex_info_s.rd]) |
                      (mem_info_s.we & hit_vec_s[mem_info_s.rd]) |
                      (wb_info_s.we & hit_vec_s[wb_info_s.rd]);
`endif
  end

  assign hazard_s = |src_s;

  // Stall/flush: reset and redirect both flush; redirect overrides a stall
  always_comb begin
    stall_s    = 1'b0;
    flush_id_s = 1'b0;
    flush_ex_s = 1'b0;
    if (!rst_n) begin
      flush_id_s = 1'b1;
      flush_ex_s = 1'b1;
    end else if (hz.ex_redirect) begin
      flush_id_s = 1'b1;
      flush_ex_s = 1'b1;
    end else if (hazard_s) begin
      stall_s    = 1'b1;
      flush_ex_s = 1'b1;
    end else begin
      stall_s    = 1'b0;
    end
  end

  // EX operand forwarding selects
  always_comb begin
    fwd_a_s = FWD_NONE;
    fwd_b_s = FWD_NONE;
    if (!rst_n) begin
      fwd_a_s = FWD_NONE;
      fwd_b_s = FWD_NONE;
    end else begin
`ifdef HAZARD_FWD_EN
      fwd_a_s = fwd_pick(hz.ex_rs1, mem_info_s, wb_info_s);
      fwd_b_s = fwd_pick(hz.ex_rs2, mem_info_s, wb_info_s);
`else
      fwd_a_s = FWD_NONE;
      fwd_b_s = FWD_NONE;
`endif
    end
  end

  // A squashed long op must not reserve its destination
  assign sb_set_s = hz.ex_valid & hz.ex_long & hz.ex_we &
                    (hz.ex_rd != {ADDR_W{1'b0}}) & ~hz.ex_redirect;
  assign sb_clr_s = hz.lc_valid & (hz.lc_rd != {ADDR_W{1'b0}});

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (sb_set_s),
    .set_rd (hz.ex_rd),
    .clr_en (sb_clr_s),
    .clr_rd (hz.lc_rd),
    .busy   (sb_busy_s)
  );

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.stall_if  = stall_s;
  assign hz.stall_id  = stall_s;
  assign hz.flush_id  = flush_id_s;
  assign hz.flush_ex  = flush_ex_s;
  assign hz.fwd_a     = fwd_a_s;
  assign hz.fwd_b     = fwd_b_s;
  assign hz.sb_busy   = sb_busy_s;
  assign hz.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: directed vector table, multi-cycle sequences and
// random stimulus against a reference model. Follows HAZARD_FWD_EN.
module tb_hazard_ctrl_sb;
  import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_we;
    logic       ex_valid;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_load;
    logic       ex_long;
    logic       ex_redirect;
    logic       mem_we;
    logic [4:0] mem_rd;
    logic       wb_we;
    logic [4:0] wb_rd;
    logic       lc_valid;
    logic [4:0] lc_rd;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [3:0] exp_ctrl;  // {stall_if, stall_id, flush_id, flush_ex}
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  bit [31:0] busy_m;
  longint    cnt_m;
  in_t       cur;

  hazard_ctrl_sb_if #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(32)) hz ();

  hazard_ctrl_sb #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic hit_m(input in_t v, input int r);
    return v.id_valid && (r != 0) &&
           ((v.id_use_rs1 && int'(v.id_rs1) == r) || (v.id_use_rs2 && int'(v.id_rs2) == r));
  endfunction

  function automatic logic hazard_m(input in_t v);
    logic h = 1'b0;
    if (v.ex_valid && v.ex_we && (v.ex_load || v.ex_long) && hit_m(v, int'(v.ex_rd))) h = 1'b1;
    for (int r = 1; r < 32; r++) if (busy_m[r] && hit_m(v, r)) h = 1'b1;
    if (v.id_valid && v.id_we && v.id_rd != 5'd0 && busy_m[v.id_rd]) h = 1'b1;
    if (!FWD_ON) begin
      if (v.ex_valid && v.ex_we && hit_m(v, int'(v.ex_rd))) h = 1'b1;
      if (v.mem_we && hit_m(v, int'(v.mem_rd))) h = 1'b1;
      if (v.wb_we && hit_m(v, int'(v.wb_rd))) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [3:0] ctrl_m(input in_t v);
    if (v.ex_redirect) return 4'b0011;
    if (hazard_m(v)) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] fsel_m(input in_t v, input logic [4:0] s);
    if (!FWD_ON || s == 5'd0) return 2'd0;
    if (v.mem_we && v.mem_rd == s) return 2'd2;
    if (v.wb_we && v.wb_rd == s) return 2'd1;
    return 2'd0;
  endfunction

  task automatic drive(input in_t v);
    hz.id_valid = v.id_valid;  hz.id_rs1 = v.id_rs1;  hz.id_rs2 = v.id_rs2;
    hz.id_use_rs1 = v.id_use_rs1;  hz.id_use_rs2 = v.id_use_rs2;
    hz.id_rd = v.id_rd;  hz.id_we = v.id_we;
    hz.ex_valid = v.ex_valid;  hz.ex_rs1 = v.ex_rs1;  hz.ex_rs2 = v.ex_rs2;
    hz.ex_rd = v.ex_rd;  hz.ex_we = v.ex_we;  hz.ex_load = v.ex_load;
    hz.ex_long = v.ex_long;  hz.ex_redirect = v.ex_redirect;
    hz.mem_we = v.mem_we;  hz.mem_rd = v.mem_rd;
    hz.wb_we = v.wb_we;  hz.wb_rd = v.wb_rd;
    hz.lc_valid = v.lc_valid;  hz.lc_rd = v.lc_rd;
    cur = v;
  endtask

  // Drive one cycle's inputs and compare every output with the model.
  task automatic apply(input in_t v);
    drive(v);
    #2;
    chk("ctrl", {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex}, ctrl_m(v));
    chk("fwd_a", hz.fwd_a, fsel_m(v, v.ex_rs1));
    chk("fwd_b", hz.fwd_b, fsel_m(v, v.ex_rs2));
    chk("sb_busy", hz.sb_busy, busy_m);
    chk("stall_cnt", hz.stall_cnt, cnt_m[31:0]);
  endtask

  // Advance the model state and the clock.
  task automatic tick();
    logic stalled;
    stalled = !cur.ex_redirect && hazard_m(cur);
    if (cur.lc_valid && cur.lc_rd != 5'd0) busy_m[cur.lc_rd] = 1'b0;
    if (cur.ex_valid && cur.ex_long && cur.ex_we && cur.ex_rd != 5'd0 && !cur.ex_redirect)
      busy_m[cur.ex_rd] = 1'b1;
    if (stalled && cnt_m < 64'hFFFF_FFFF) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex}, 4'b0011);
    chk({tag, "_fwd"}, {hz.fwd_a, hz.fwd_b}, 4'b0000);
    chk({tag, "_busy"}, hz.sb_busy, 32'd0);
    chk({tag, "_cnt"}, hz.stall_cnt, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(in_t'(0));
    #2;
    check_reset_outputs("reset");
    busy_m = '0;
    cnt_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic in_t long_op(input logic [4:0] rd);
    in_t v = '0;
    v.ex_valid = 1'b1; v.ex_we = 1'b1; v.ex_long = 1'b1; v.ex_rd = rd;
    return v;
  endfunction

  function automatic in_t reads(input logic [4:0] rs);
    in_t v = '0;
    v.id_valid = 1'b1; v.id_use_rs1 = 1'b1; v.id_rs1 = rs;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t e;
    in_t  v;

    do_reset();

    // Directed table (scoreboard empty throughout)
    v = '0;
    e = '{"idle", v, 4'b0000, 2'd0, 2'd0}; vecs.push_back(e);
    v = reads(5'd5); v.ex_valid = 1; v.ex_we = 1; v.ex_load = 1; v.ex_rd = 5'd5;
    e = '{"load_use", v, 4'b1101, 2'd0, 2'd0}; vecs.push_back(e);
    v.ex_redirect = 1;
    e = '{"load_use_redirect", v, 4'b0011, 2'd0, 2'd0}; vecs.push_back(e);
    v = reads(5'd0); v.ex_valid = 1; v.ex_we = 1; v.ex_load = 1; v.ex_rd = 5'd0;
    e = '{"load_x0", v, 4'b0000, 2'd0, 2'd0}; vecs.push_back(e);
    v = reads(5'd5); v.id_use_rs1 = 0; v.ex_valid = 1; v.ex_we = 1; v.ex_load = 1; v.ex_rd = 5'd5;
    e = '{"load_unused_src", v, 4'b0000, 2'd0, 2'd0}; vecs.push_back(e);
    v = '0; v.mem_we = 1; v.mem_rd = 5'd3; v.wb_we = 1; v.wb_rd = 5'd3; v.ex_rs1 = 5'd3;
    e = '{"fwd_mem_prio", v, 4'b0000, FWD_ON ? 2'd2 : 2'd0, 2'd0}; vecs.push_back(e);
    v = '0; v.id_valid = 1; v.id_use_rs2 = 1; v.id_rs2 = 5'd6; v.wb_we = 1; v.wb_rd = 5'd6; v.ex_rs2 = 5'd6;
    e = '{"wb_match", v, FWD_ON ? 4'b0000 : 4'b1101, 2'd0, FWD_ON ? 2'd1 : 2'd0}; vecs.push_back(e);
    v = '0; v.mem_rd = 5'd8; v.wb_we = 1; v.wb_rd = 5'd8; v.ex_rs1 = 5'd8;
    e = '{"fwd_wb_mem_off", v, 4'b0000, FWD_ON ? 2'd1 : 2'd0, 2'd0}; vecs.push_back(e);
    v = reads(5'd10); v.ex_valid = 1; v.ex_we = 1; v.ex_rd = 5'd10;
    e = '{"alu_ex_match", v, FWD_ON ? 4'b0000 : 4'b1101, 2'd0, 2'd0}; vecs.push_back(e);
    v = reads(5'd5); v.ex_we = 1; v.ex_load = 1; v.ex_rd = 5'd5;
    e = '{"load_ex_invalid", v, 4'b0000, 2'd0, 2'd0}; vecs.push_back(e);
    v = '0; v.mem_we = 1; v.mem_rd = 5'd5; v.ex_rs1 = 5'd5; v.ex_rs2 = 5'd5;
    e = '{"fwd_both_mem", v, 4'b0000, FWD_ON ? 2'd2 : 2'd0, FWD_ON ? 2'd2 : 2'd0}; vecs.push_back(e);
    v = '0; v.mem_we = 1; v.mem_rd = 5'd0; v.wb_we = 1; v.wb_rd = 5'd0;
    e = '{"fwd_x0", v, 4'b0000, 2'd0, 2'd0}; vecs.push_back(e);

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      chk({vecs[i].name, "_ctrl"}, {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex}, vecs[i].exp_ctrl);
      chk({vecs[i].name, "_fwd_a"}, hz.fwd_a, vecs[i].exp_a);
      chk({vecs[i].name, "_fwd_b"}, hz.fwd_b, vecs[i].exp_b);
      tick();
    end

    // Load-use stalls one cycle, then the consumer in EX picks up MEM
    do_reset();
    v = reads(5'd5); v.ex_valid = 1; v.ex_we = 1; v.ex_load = 1; v.ex_rd = 5'd5;
    apply(v);
    chk("lu_stall", {hz.stall_if, hz.stall_id, hz.flush_ex}, 3'b111);
    tick();
    v = '0; v.ex_valid = 1; v.ex_we = 1; v.ex_rd = 5'd6; v.ex_rs1 = 5'd5; v.mem_we = 1; v.mem_rd = 5'd5;
    apply(v);
    chk("lu_fwd_a", hz.fwd_a, FWD_ON ? 2'd2 : 2'd0);
    tick();

    // Long op on x7 holds ID until the cycle after lc_valid
    do_reset();
    apply(long_op(5'd7)); tick();
    for (int i = 0; i < 3; i++) begin
      apply(reads(5'd7));
      chk("long_stall", hz.stall_id, 1'b1);
      chk("long_busy", hz.sb_busy[7], 1'b1);
      tick();
    end
    v = reads(5'd7); v.lc_valid = 1; v.lc_rd = 5'd7;
    apply(v);
    chk("long_no_bypass", hz.stall_id, 1'b1);
    tick();
    apply(reads(5'd7));
    chk("long_release", hz.stall_id, 1'b0);
    chk("long_cleared", hz.sb_busy[7], 1'b0);
    tick();

    // Same-cycle set/clear of x9, WAW on busy, clear of a non-busy register
    do_reset();
    apply(long_op(5'd9)); tick();
    v = long_op(5'd9); v.lc_valid = 1; v.lc_rd = 5'd9;
    apply(v); tick();
    v = '0; v.lc_valid = 1; v.lc_rd = 5'd12;
    apply(v);
    chk("collide_busy", hz.sb_busy[9], 1'b1);
    tick();
    v = '0; v.id_valid = 1; v.id_we = 1; v.id_rd = 5'd9;
    apply(v);
    chk("waw_stall", hz.stall_id, 1'b1);
    chk("clr_nonbusy", hz.sb_busy, 32'h0000_0200);
    tick();

    // Redirect squashes a long op and overrides its stall
    do_reset();
    v = long_op(5'd11); v.ex_redirect = 1; v.id_valid = 1; v.id_use_rs1 = 1; v.id_rs1 = 5'd11;
    apply(v);
    chk("redir_ctrl", {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex}, 4'b0011);
    tick();
    apply('0);
    chk("redir_no_set", hz.sb_busy[11], 1'b0);
    tick();

    // Random stimulus against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v = '0;
      v.id_valid = ($urandom_range(0, 9) < 8);
      v.id_rs1 = 5'($urandom_range(0, 7)); v.id_rs2 = 5'($urandom_range(0, 7));
      v.id_use_rs1 = 1'($urandom); v.id_use_rs2 = 1'($urandom);
      v.id_rd = 5'($urandom_range(0, 7)); v.id_we = 1'($urandom);
      v.ex_valid = 1'($urandom); v.ex_rs1 = 5'($urandom_range(0, 7));
      v.ex_rs2 = 5'($urandom_range(0, 7)); v.ex_rd = 5'($urandom_range(0, 7));
      v.ex_we = 1'($urandom); v.ex_load = ($urandom_range(0, 3) == 0);
      v.ex_long = ($urandom_range(0, 7) == 0); v.ex_redirect = ($urandom_range(0, 15) == 0);
      v.mem_we = 1'($urandom); v.mem_rd = 5'($urandom_range(0, 7));
      v.wb_we = 1'($urandom); v.wb_rd = 5'($urandom_range(0, 7));
      v.lc_valid = ($urandom_range(0, 3) == 0); v.lc_rd = 5'($urandom_range(0, 7));
      apply(v);
      tick();
    end

    // Reset asserted mid-stall clears scoreboard and counter at once
    do_reset();
    apply(long_op(5'd4)); tick();
    for (int i = 0; i < 17; i++) begin
      apply(reads(5'd4)); tick();
    end
    apply(reads(5'd4));
    chk("pre_reset_cnt", hz.stall_cnt, 32'd17);
    chk("pre_reset_busy", hz.sb_busy[4], 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    busy_m = '0;
    cnt_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply('0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
